// File: rtl/mem_responder.sv
// mem_responder: single-outstanding request responder over a word-organised SRAM.
// One request is accepted from IDLE; a one-cycle response pulse follows LATENCY cycles later.
module mem_responder #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DEPTH_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned       LATENCY     = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              reqValid,
   input  logic              wen,
   input  logic [1:0]        size,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              respValid,
   output logic [31:0]       rdata,
   output logic              respError,
   output logic              busy
);

   localparam int unsigned       IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_W:0]   SPAN     = (ADDR_W+1)'(DEPTH_WORDS) << 2;
   localparam logic [3:0]        LAT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t state, state_next;
   logic [3:0] count, count_next;

   logic              accept;
   logic [ADDR_W-1:0] off;
   logic [IDX_W-1:0]  idx;
   logic              below;
   logic              above;
   logic              misaligned;
   logic              req_err;
   logic [3:0]        strobe;
   logic [31:0]       lane_data;

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rd_word;

   logic        err_q;
   logic        wen_q;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic [31:0] shifted;
   logic [31:0] load_data;

   // Request decode: range, alignment and byte-lane steering of the incoming request
   always_comb begin
      off   = addr - BASE_ADDR;
      idx   = off[IDX_W+1:2];
      below = (addr < BASE_ADDR);
      above = ({1'b0, off} >= SPAN);
      unique case (size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = addr[0];
         2'd2:    misaligned = (addr[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
      req_err = below | above | misaligned | (size == 2'd3);

      strobe    = 4'b0000;
      lane_data = wdata;
      unique case (size)
         2'd0: begin
            strobe    = 4'b0001 << addr[1:0];
            lane_data = {4{wdata[7:0]}};
         end
         2'd1: begin
            strobe    = addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata[15:0]}};
         end
         2'd2: begin
            strobe    = 4'b1111;
            lane_data = wdata;
         end
         default: begin
            strobe    = 4'b0000;
            lane_data = wdata;
         end
      endcase
   end

   assign accept = (state == IDLE) && reqValid;

   // SRAM access happens on the accept edge; later requests therefore see any store
   always_ff @(posedge clock) begin
      if (accept && !req_err) begin
         if (wen) begin
            for (int unsigned b = 0; b < 4; b++) begin
               if (strobe[b]) begin
                  mem[idx][8*b +: 8] <= lane_data[8*b +: 8];
               end
            end
         end else begin
            rd_word <= mem[idx];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         err_q  <= 1'b0;
         wen_q  <= 1'b0;
         size_q <= '0;
         lane_q <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (accept) begin
            err_q  <= req_err;
            wen_q  <= wen;
            size_q <= size;
            lane_q <= addr[1:0];
         end
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      unique case (state)
         IDLE: begin
            if (reqValid) begin
               if (LATENCY == 1) begin
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
                  count_next = LAT_INIT;
               end
            end
         end
         WAIT: begin
            if (count == 4'd1) begin
               state_next = RESP;
               count_next = '0;
            end else begin
               count_next = count - 4'd1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Response shaping: gated by RESP so outputs read zero outside the pulse
   always_comb begin
      shifted = rd_word >> {lane_q, 3'b000};
      unique case (size_q)
         2'd0:    load_data = {24'b0, shifted[7:0]};
         2'd1:    load_data = {16'b0, shifted[15:0]};
         default: load_data = shifted;
      endcase
      respValid = (state == RESP);
      busy      = (state != IDLE);
      respError = respValid && err_q;
      rdata     = (respValid && !err_q && !wen_q) ? load_data : '0;
   end

endmodule
